// File: rtl/dot_frame_writer_if.sv
// Row-write bus between control logic and dot_frame_writer (valid/ready handshake).
// DOT_FRAME_WRITER_MASK_EN adds a per-column write mask to the bus.
interface dot_frame_writer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_r;
    logic [7:0] wr_g;
    logic       wr_last;
`ifdef DOT_FRAME_WRITER_MASK_EN
    logic [7:0] wr_mask;

    modport master (
        output wr_valid, wr_row, wr_r, wr_g, wr_last, wr_mask,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_row, wr_r, wr_g, wr_last, wr_mask,
        output wr_ready
    );
`else
    modport master (
        output wr_valid, wr_row, wr_r, wr_g, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_row, wr_r, wr_g, wr_last,
        output wr_ready
    );
`endif
endinterface

// File: rtl/dot_frame_writer.sv
// Double-buffered 8x8 bicolour picture writer: rows land in a back buffer, which is copied
// to the displayed front buffer on scan wrap. Optional macro: DOT_FRAME_WRITER_MASK_EN.
module dot_frame_writer #(
    parameter logic [63:0] DEFAULT_R      = 64'h0,
    parameter logic [63:0] DEFAULT_G      = 64'h0,
    parameter bit          SWAP_IMMEDIATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    dot_frame_writer_if.slave     wr,
    input  logic                  scan_wrap,
    output logic [63:0]           PICTURE_R,
    output logic [63:0]           PICTURE_G,
    output logic                  frame_done,
    output logic [7:0]            swap_count
);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] back_r;
    logic [63:0] back_g;
    logic [5:0]  row_base;
    logic [7:0]  mask;
    logic [7:0]  merged_r;
    logic [7:0]  merged_g;
    logic        accept;
    logic        swap_now;

    assign row_base = {wr.wr_row, 3'b000};
    assign accept   = wr.wr_valid && wr.wr_ready;
    assign swap_now = SWAP_IMMEDIATE || scan_wrap;

`ifdef DOT_FRAME_WRITER_MASK_EN
    assign mask = wr.wr_mask;
`else
    assign mask = 8'hFF;
`endif

    // Read-modify-write merge; an all-ones mask degenerates to a plain row replace.
    always_comb begin
        merged_r = (back_r[row_base +: 8] & ~mask) | (wr.wr_r & mask);
        merged_g = (back_g[row_base +: 8] & ~mask) | (wr.wr_g & mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wr.wr_ready <= 1'b1;
            back_r      <= DEFAULT_R;
            back_g      <= DEFAULT_G;
            PICTURE_R   <= DEFAULT_R;
            PICTURE_G   <= DEFAULT_G;
            frame_done  <= 1'b0;
            swap_count  <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        back_r[row_base +: 8] <= merged_r;
                        back_g[row_base +: 8] <= merged_g;
                        if (wr.wr_last) begin
                            state       <= PEND;
                            wr.wr_ready <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    // Copy rather than exchange, so later frames may touch only a few rows.
                    if (swap_now) begin
                        PICTURE_R   <= back_r;
                        PICTURE_G   <= back_g;
                        frame_done  <= 1'b1;
                        swap_count  <= swap_count + 8'd1;
                        state       <= FILL;
                        wr.wr_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= FILL;
                    wr.wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_frame_writer.sv
// Directed self-checking bench for dot_frame_writer: one scan-wrap instance and one
// SWAP_IMMEDIATE instance sharing clock and reset.
module tb_dot_frame_writer;

    localparam logic [63:0] A_DEF_R = 64'h0102040810204080;
    localparam logic [63:0] A_DEF_G = 64'h0;
    localparam logic [63:0] B_DEF_R = 64'h0;
    localparam logic [63:0] B_DEF_G = 64'h0123456789ABCDEF;

    logic        clk;
    logic        rst;
    logic        scan_wrap_a;
    logic        scan_wrap_b;
    logic [63:0] pic_r_a, pic_g_a, pic_r_b, pic_g_b;
    logic        done_a, done_b;
    logic [7:0]  count_a, count_b;

    int checks = 0;
    int errors = 0;
    int pulses;

    dot_frame_writer_if bus_a ();
    dot_frame_writer_if bus_b ();

    dot_frame_writer #(
        .DEFAULT_R(A_DEF_R),
        .DEFAULT_G(A_DEF_G),
        .SWAP_IMMEDIATE(1'b0)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .wr(bus_a),
        .scan_wrap(scan_wrap_a),
        .PICTURE_R(pic_r_a),
        .PICTURE_G(pic_g_a),
        .frame_done(done_a),
        .swap_count(count_a)
    );

    dot_frame_writer #(
        .DEFAULT_R(B_DEF_R),
        .DEFAULT_G(B_DEF_G),
        .SWAP_IMMEDIATE(1'b1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .wr(bus_b),
        .scan_wrap(scan_wrap_b),
        .PICTURE_R(pic_r_b),
        .PICTURE_G(pic_g_b),
        .frame_done(done_b),
        .swap_count(count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic write_a(input logic [2:0] row, input logic [7:0] r, input logic [7:0] g, input logic last);
        bus_a.wr_valid = 1'b1;
        bus_a.wr_row   = row;
        bus_a.wr_r     = r;
        bus_a.wr_g     = g;
        bus_a.wr_last  = last;
        tick();
        bus_a.wr_valid = 1'b0;
        bus_a.wr_last  = 1'b0;
    endtask

    task automatic write_b(input logic [2:0] row, input logic [7:0] r, input logic [7:0] g, input logic last);
        bus_b.wr_valid = 1'b1;
        bus_b.wr_row   = row;
        bus_b.wr_r     = r;
        bus_b.wr_g     = g;
        bus_b.wr_last  = last;
        tick();
        bus_b.wr_valid = 1'b0;
        bus_b.wr_last  = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        scan_wrap_a    = 1'b0;
        scan_wrap_b    = 1'b0;
        bus_a.wr_valid = 1'b0;
        bus_a.wr_row   = 3'd0;
        bus_a.wr_r     = 8'h00;
        bus_a.wr_g     = 8'h00;
        bus_a.wr_last  = 1'b0;
        bus_b.wr_valid = 1'b0;
        bus_b.wr_row   = 3'd0;
        bus_b.wr_r     = 8'h00;
        bus_b.wr_g     = 8'h00;
        bus_b.wr_last  = 1'b0;
`ifdef DOT_FRAME_WRITER_MASK_EN
        bus_a.wr_mask  = 8'hFF;
        bus_b.wr_mask  = 8'hFF;
`endif

        // Reset values visible before the first clock edge
        #1;
        check_output("reset_pic_r_a", pic_r_a, A_DEF_R);
        check_output("reset_pic_g_a", pic_g_a, A_DEF_G);
        check_output("reset_ready_a", {63'd0, bus_a.wr_ready}, 64'd1);
        check_output("reset_done_a", {63'd0, done_a}, 64'd0);
        check_output("reset_count_a", {56'd0, count_a}, 64'd0);
        check_output("reset_pic_g_b", pic_g_b, B_DEF_G);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;

        // Full frame of red, swap on scan_wrap five cycles after wr_last
        for (int k = 0; k < 8; k++) begin
            write_a(k[2:0], 8'hFF, 8'h00, k == 7);
        end
        bus_a.wr_valid = 1'b1;
        bus_a.wr_row   = 3'd0;
        bus_a.wr_r     = 8'h00;
        bus_a.wr_g     = 8'hFF;
        bus_a.wr_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_output("pend_ready", {63'd0, bus_a.wr_ready}, 64'd0);
            check_output("pend_pic_r", pic_r_a, A_DEF_R);
            check_output("pend_done", {63'd0, done_a}, 64'd0);
            tick();
        end
        bus_a.wr_valid = 1'b0;
        bus_a.wr_last  = 1'b0;
        scan_wrap_a    = 1'b1;
        tick();
        scan_wrap_a    = 1'b0;
        check_output("swap1_pic_r", pic_r_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("swap1_pic_g", pic_g_a, 64'h0);
        check_output("swap1_done", {63'd0, done_a}, 64'd1);
        check_output("swap1_count", {56'd0, count_a}, 64'd1);
        check_output("swap1_ready", {63'd0, bus_a.wr_ready}, 64'd1);
        tick();
        check_output("swap1_done_clear", {63'd0, done_a}, 64'd0);

        // wr_last coinciding with scan_wrap must wait for the next scan_wrap
        pulses = 0;
        scan_wrap_a = 1'b1;
        write_a(3'd2, 8'h3C, 8'h11, 1'b1);
        scan_wrap_a = 1'b0;
        pulses += int'(done_a);
        check_output("coinc_done", {63'd0, done_a}, 64'd0);
        check_output("coinc_ready", {63'd0, bus_a.wr_ready}, 64'd0);
        check_output("coinc_pic_r", pic_r_a, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (19) begin
            tick();
            pulses += int'(done_a);
        end
        scan_wrap_a = 1'b1;
        tick();
        scan_wrap_a = 1'b0;
        pulses += int'(done_a);
        check_output("swap2_pic_r", pic_r_a, 64'hFFFF_FFFF_FF3C_FFFF);
        check_output("swap2_pic_g", pic_g_a, 64'h0000_0000_0011_0000);
        check_output("swap2_count", {56'd0, count_a}, 64'd2);
        repeat (3) begin
            tick();
            pulses += int'(done_a);
        end
        check_output("swap2_pulses", 64'(pulses), 64'd1);

        // Partial update of row 3 green only
        write_a(3'd3, 8'hFF, 8'hA5, 1'b1);
        scan_wrap_a = 1'b1;
        tick();
        scan_wrap_a = 1'b0;
        check_output("partial_pic_g", pic_g_a, 64'h0000_0000_A511_0000);
        check_output("partial_pic_r", pic_r_a, 64'hFFFF_FFFF_FF3C_FFFF);
        check_output("partial_count", {56'd0, count_a}, 64'd3);

        // Reset while a swap is pending discards it
        write_a(3'd5, 8'h00, 8'h00, 1'b1);
        check_output("rstpend_ready", {63'd0, bus_a.wr_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check_output("rstpend_pic_r", pic_r_a, A_DEF_R);
        check_output("rstpend_pic_g", pic_g_a, A_DEF_G);
        check_output("rstpend_count", {56'd0, count_a}, 64'd0);
        check_output("rstpend_ready_hi", {63'd0, bus_a.wr_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        scan_wrap_a = 1'b1;
        tick();
        scan_wrap_a = 1'b0;
        check_output("rstpend_no_done", {63'd0, done_a}, 64'd0);
        check_output("rstpend_no_swap", pic_r_a, A_DEF_R);
        check_output("rstpend_count2", {56'd0, count_a}, 64'd0);

        // Immediate-swap instance: one-cycle latency, then wrap swap_count through 256 swaps
        write_b(3'd4, 8'h77, 8'h00, 1'b1);
        check_output("imm_pic_r_n", pic_r_b, B_DEF_R);
        check_output("imm_done_n", {63'd0, done_b}, 64'd0);
        check_output("imm_ready_n", {63'd0, bus_b.wr_ready}, 64'd0);
        tick();
        check_output("imm_pic_r_n1", pic_r_b, 64'h0000_0077_0000_0000);
        check_output("imm_pic_g_n1", pic_g_b, 64'h0123_4500_89AB_CDEF);
        check_output("imm_done_n1", {63'd0, done_b}, 64'd1);
        check_output("imm_count_n1", {56'd0, count_b}, 64'd1);
        pulses = 0;
        for (int i = 0; i < 254; i++) begin
            write_b(3'd0, 8'h00, 8'h00, 1'b1);
            tick();
            pulses += int'(done_b);
        end
        check_output("imm_pulses", 64'(pulses), 64'd254);
        check_output("imm_count_255", {56'd0, count_b}, 64'd255);
        write_b(3'd0, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("imm_count_wrap", {56'd0, count_b}, 64'd0);
        check_output("imm_done_wrap", {63'd0, done_b}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_frame_writer.md
Name: dot_frame_writer

Overview:
- Producer side of the 8x8 bicolour dot-matrix picture bus: accepts row writes from control logic over a valid/ready handshake.
- Assembles the rows in a back buffer and presents a stable front buffer on PICTURE_R/PICTURE_G to the row-scanning matrix driver.
- Front/back swap waits for a scan-wrap pulse, so a frame is never shown half old, half new.

Parameters:
- DEFAULT_R, 64'h0, red image loaded into front and back buffers on reset
- DEFAULT_G, 64'h0, green image loaded into front and back buffers on reset
- SWAP_IMMEDIATE, 0, 1 = commit swaps on the cycle after wr_last, without waiting for scan_wrap

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- wr_valid  input  1  row write request
- wr_ready  output  1  block can accept a row write
- wr_row  input  3  target row index 0..7
- wr_r  input  8  red column bits for that row
- wr_g  input  8  green column bits for that row
- wr_last  input  1  this write completes the frame; request a swap
- scan_wrap  input  1  one-cycle pulse from scanner when its row scan restarts at row 0
- PICTURE_R  output  64  displayed red frame; row k at bits [8k+7:8k]
- PICTURE_G  output  64  displayed green frame; same packing
- frame_done  output  1  one-cycle pulse on the cycle the front buffer updates
- swap_count  output  8  number of completed swaps, wraps 255->0

Behaviour:
- Reset (async assert, any state):
  - back and front buffers = DEFAULT_R/DEFAULT_G; PICTURE_R/G = DEFAULT_R/DEFAULT_G.
  - state = FILL; wr_ready = 1; frame_done = 0; swap_count = 0.
  - Any pending swap is discarded.
- Handshake:
  - A write is accepted on a posedge where wr_valid & wr_ready.
  - wr_ready is a registered function of state: 1 in FILL, 0 in PEND.
  - Inputs are ignored when wr_ready = 0. A master holding wr_valid keeps its data stable until accepted.
- Row write: on acceptance, back[8*wr_row +: 8] <= wr_r/wr_g. Other rows are untouched. Rewriting the same row before wr_last: last write wins.
- States:
  - FILL: accepts writes. An accepted write with wr_last=1 stores the row and moves to PEND on the same edge. wr_last is only honoured together with an accepted write.
  - PEND (SWAP_IMMEDIATE=0): wait for scan_wrap=1 sampled at a posedge. On that edge, front <= back, frame_done <= 1 for one cycle, swap_count++, and next state = FILL.
  - PEND (SWAP_IMMEDIATE=1): swap on the first posedge in PEND regardless of scan_wrap, so latency = 1 cycle after wr_last acceptance.
- Swap semantics: copy, not exchange. The back buffer keeps its contents, so the next frame may update only some rows.
- Latency: PICTURE_R/G and frame_done change on the same edge as the swap. PICTURE outputs are driven directly from front buffer registers, with no combinational path from inputs.
- Simultaneous events:
  - scan_wrap in FILL is ignored.
  - wr_last accepted on the same edge scan_wrap=1 does not swap; the block enters PEND and waits for the next scan_wrap.
  - scan_wrap pulses while in PEND beyond the first are irrelevant, because the block leaves PEND on the first one.
- PICTURE outputs never change except on a swap edge or reset.
- swap_count wraps modulo 256 with no saturation flag.
- The scanner samples PICTURE on negedge. Outputs are stable across the whole cycle after a posedge update, so no extra synchronisation is required.

Optional Feature:
- Macro DOT_FRAME_WRITER_MASK_EN.
- When defined:
  - Adds input wr_mask [7:0].
  - An accepted write performs a read-modify-write merge: back row bit i <= wr_mask[i] ? new bit : old bit, for both colours.
  - wr_mask = 8'h00 leaves the row unchanged but still honours wr_last.
- When undefined: the wr_mask port is absent and writes replace the whole row, equivalent to wr_mask = 8'hFF.

Test Plan:
- Reset with DEFAULT_R=64'h0102040810204080: PICTURE_R = 64'h0102040810204080 and wr_ready=1 immediately on async rst assert, before any clk edge.
- Write rows 0..7 with wr_r=8'hFF, wr_g=8'h00, wr_last on row 7, then scan_wrap 5 cycles later:
  - wr_ready=0 for those 5 cycles; PICTURE_R unchanged.
  - On the scan_wrap edge, PICTURE_R = 64'hFFFF_FFFF_FFFF_FFFF, frame_done pulses once, swap_count = 1.
- wr_last accepted on the same edge as scan_wrap: no swap; next scan_wrap 20 cycles later performs the swap. frame_done pulses exactly once.
- Partial update: after a full frame, write only row 3 with wr_g=8'hA5 and wr_last, then scan_wrap. Only PICTURE_G[31:24] = 8'hA5; all other bits keep their prior values.
- Assert rst in PEND with a swap pending: outputs return to DEFAULT_*, swap_count=0. A later scan_wrap causes no swap and no frame_done.
- SWAP_IMMEDIATE=1 build: wr_last at edge N updates PICTURE at edge N+1 with scan_wrap held 0. Perform 256 swaps and check swap_count wraps to 0.
